// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding, reset
// cause codes and a counter-width helper.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  typedef logic [1:0] cause_t;

  localparam cause_t CAUSE_POWER  = 2'b01;
  localparam cause_t CAUSE_BUTTON = 2'b10;
  localparam cause_t CAUSE_SW     = 2'b11;

  // Bits needed to hold the values 0..n-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Push-button conditioner: two-flop synchroniser followed by a stable-count
// filter. The output follows the synchronised input only after the two have
// differed for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
// Ports:
//   clk    - system clock
//   reset  - asynchronous active-high reset (output and synchroniser go to 1)
//   din_n  - raw active-low button, asynchronous to clk
//   dout_n - debounced active-low button
module button_debounce
  import reset_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic din_n,
  output logic dout_n
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      dout_n <= 1'b1;
      cnt    <= '0;
    end else begin
      sync1 <= din_n;
      sync2 <= sync1;
      if (sync2 == dout_n) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        dout_n <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Staged SoC reset generator. All reset_n_out bits assert together and are
// released one at a time (bit 0 first) after a hold period. Triggers are the
// asynchronous power/PLL reset, a debounced push-button and a one-cycle
// software request. The cause of the last reset is kept for software.
// Ports:
//   clk            - system clock
//   reset          - asynchronous active-high power/PLL reset
//   reset_button_n - raw active-low board button
//   sw_reset_req   - one-cycle software reset request (clk domain)
//   reset_n_out    - per-stage active-low resets, bit 0 released first
//   seq_done       - high once every stage is released
//   reset_cause    - 01 power, 10 button, 11 software (sticky)
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES      = 3,
  parameter int unsigned HOLD_CYCLES     = 64,
  parameter int unsigned STAGE_GAP       = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reset_button_n,
  input  logic                  sw_reset_req,
  output logic [NUM_STAGES-1:0] reset_n_out,
  output logic                  seq_done,
  output logic [1:0]            reset_cause
);

  localparam int unsigned CNT_W = cnt_width(HOLD_CYCLES);
  localparam int unsigned GAP_W = cnt_width(STAGE_GAP);
  localparam int unsigned STG_W = cnt_width(NUM_STAGES + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(STAGE_GAP - 1);
  localparam logic [STG_W-1:0] STG_LAST = STG_W'(NUM_STAGES - 1);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [STG_W-1:0]      stg_q, stg_d;
  logic [NUM_STAGES-1:0] out_q, out_d;
  logic                  done_q, done_d;
  cause_t                cause_q, cause_d;

  logic [1:0] rst_sync;
  logic       run_ok;
  logic       btn_n;
  logic       btn_trig;
  logic       any_trig;

  // Reset assertion acts immediately; the hold count only starts once the
  // release has passed through two flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rst_sync <= '0;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign run_ok = rst_sync[1];

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_button_debounce (
    .clk   (clk),
    .reset (reset),
    .din_n (reset_button_n),
    .dout_n(btn_n)
  );

  assign btn_trig = ~btn_n;
  assign any_trig = btn_trig | sw_reset_req;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    stg_d   = stg_q;
    out_d   = out_q;
    done_d  = done_q;
    cause_d = cause_q;

    case (state_q)
      ST_ASSERT: begin
        out_d  = '0;
        done_d = 1'b0;
        if (btn_trig || !run_ok) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (NUM_STAGES == 1) begin
            state_d = ST_RUN;
            out_d   = '1;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RELEASE;
            out_d   = NUM_STAGES'(1);
            stg_d   = STG_W'(1);
            gap_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RELEASE: begin
        if (any_trig) begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
          out_d   = '0;
          done_d  = 1'b0;
          cause_d = btn_trig ? CAUSE_BUTTON : CAUSE_SW;
        end else if (gap_q == GAP_LAST) begin
          gap_d = '0;
          stg_d = stg_q + 1'b1;
          for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            if (STG_W'(i) == stg_q) begin
              out_d[i] = 1'b1;
            end
          end
          if (stg_q == STG_LAST) begin
            state_d = ST_RUN;
            done_d  = 1'b1;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      ST_RUN: begin
        if (any_trig) begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
          out_d   = '0;
          done_d  = 1'b0;
          cause_d = btn_trig ? CAUSE_BUTTON : CAUSE_SW;
        end
      end

      default: begin
        state_d = ST_ASSERT;
        cnt_d   = '0;
        out_d   = '0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      gap_q   <= '0;
      stg_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
      cause_q <= CAUSE_POWER;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      stg_q   <= stg_d;
      out_q   <= out_d;
      done_q  <= done_d;
      cause_q <= cause_d;
    end
  end

  assign reset_n_out = out_q;
  assign seq_done    = done_q;
  assign reset_cause = cause_q;

endmodule
